// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures every decode-stage field on each rising clk, one-cycle latency.
// No enable, stall or flush; asynchronous active-high reset clears all outputs immediately.
module id_ex_reg #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 3,
  parameter int FUNCT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hit,
  input  logic [DATA_W-1:0]  readData1,
  input  logic [DATA_W-1:0]  readData2,
  input  logic [DATA_W-1:0]  signExImmediate,
  input  logic               RegDst,
  input  logic               ALUSrc,
  input  logic               MemtoReg,
  input  logic               RegWrite,
  input  logic               MemRead,
  input  logic               MemWrite,
  input  logic               Branch,
  input  logic [ALUOP_W-1:0] ALUOp,
  input  logic [REG_W-1:0]   rt,
  input  logic [REG_W-1:0]   rd,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [DATA_W-1:0]  nextPc,
  output logic               hit_OUT,
  output logic [DATA_W-1:0]  readData1_OUT,
  output logic [DATA_W-1:0]  readData2_OUT,
  output logic [DATA_W-1:0]  signExImmediate_OUT,
  output logic               RegDst_OUT,
  output logic               ALUSrc_OUT,
  output logic               MemtoReg_OUT,
  output logic               RegWrite_OUT,
  output logic               MemRead_OUT,
  output logic               MemWrite_OUT,
  output logic               Branch_OUT,
  output logic [ALUOP_W-1:0] ALUOp_OUT,
  output logic [REG_W-1:0]   rt_OUT,
  output logic [REG_W-1:0]   rd_OUT,
  output logic [FUNCT_W-1:0] funct_OUT,
  output logic [DATA_W-1:0]  nextPc_OUT
);

  typedef struct packed {
    logic               hit;
    logic [DATA_W-1:0]  read_data1;
    logic [DATA_W-1:0]  read_data2;
    logic [DATA_W-1:0]  imm;
    logic               reg_dst;
    logic               alu_src;
    logic               mem_to_reg;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               branch;
    logic [ALUOP_W-1:0] alu_op;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   rd;
    logic [FUNCT_W-1:0] funct;
    logic [DATA_W-1:0]  next_pc;
  } id_ex_t;

  id_ex_t stage_d;
  id_ex_t stage_q;

  always_comb begin
    stage_d            = '0;
    stage_d.hit        = hit;
    stage_d.read_data1 = readData1;
    stage_d.read_data2 = readData2;
    stage_d.imm        = signExImmediate;
    stage_d.reg_dst    = RegDst;
    stage_d.alu_src    = ALUSrc;
    stage_d.mem_to_reg = MemtoReg;
    stage_d.reg_write  = RegWrite;
    stage_d.mem_read   = MemRead;
    stage_d.mem_write  = MemWrite;
    stage_d.branch     = Branch;
    stage_d.alu_op     = ALUOp;
    stage_d.rt         = rt;
    stage_d.rd         = rd;
    stage_d.funct      = funct;
    stage_d.next_pc    = nextPc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign hit_OUT             = stage_q.hit;
  assign readData1_OUT       = stage_q.read_data1;
  assign readData2_OUT       = stage_q.read_data2;
  assign signExImmediate_OUT = stage_q.imm;
  assign RegDst_OUT          = stage_q.reg_dst;
  assign ALUSrc_OUT          = stage_q.alu_src;
  assign MemtoReg_OUT        = stage_q.mem_to_reg;
  assign RegWrite_OUT        = stage_q.reg_write;
  assign MemRead_OUT         = stage_q.mem_read;
  assign MemWrite_OUT        = stage_q.mem_write;
  assign Branch_OUT          = stage_q.branch;
  assign ALUOp_OUT           = stage_q.alu_op;
  assign rt_OUT              = stage_q.rt;
  assign rd_OUT              = stage_q.rd;
  assign funct_OUT           = stage_q.funct;
  assign nextPc_OUT          = stage_q.next_pc;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed + randomized bench for id_ex_reg; expected outputs come from the stage-register rule:
// after each rising edge the outputs equal the inputs seen at that edge, or zero if rst was high.
module tb_id_ex_reg;

  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;
  localparam int ALUOP_W = 3;
  localparam int FUNCT_W = 6;

  typedef struct packed {
    logic               hit;
    logic [DATA_W-1:0]  rd1;
    logic [DATA_W-1:0]  rd2;
    logic [DATA_W-1:0]  imm;
    logic [6:0]         ctl;   // RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch
    logic [ALUOP_W-1:0] aluop;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   rd;
    logic [FUNCT_W-1:0] funct;
    logic [DATA_W-1:0]  npc;
  } vec_t;

  localparam int VW = $bits(vec_t);

  logic clk;
  logic rst;
  vec_t cur;
  vec_t got;
  vec_t exp_v;
  int   checks;
  int   errors;

  logic               hit_OUT;
  logic [DATA_W-1:0]  readData1_OUT, readData2_OUT, signExImmediate_OUT, nextPc_OUT;
  logic               RegDst_OUT, ALUSrc_OUT, MemtoReg_OUT, RegWrite_OUT;
  logic               MemRead_OUT, MemWrite_OUT, Branch_OUT;
  logic [ALUOP_W-1:0] ALUOp_OUT;
  logic [REG_W-1:0]   rt_OUT, rd_OUT;
  logic [FUNCT_W-1:0] funct_OUT;

  id_ex_reg #(
    .DATA_W(DATA_W), .REG_W(REG_W), .ALUOP_W(ALUOP_W), .FUNCT_W(FUNCT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .hit(cur.hit), .readData1(cur.rd1), .readData2(cur.rd2), .signExImmediate(cur.imm),
    .RegDst(cur.ctl[6]), .ALUSrc(cur.ctl[5]), .MemtoReg(cur.ctl[4]), .RegWrite(cur.ctl[3]),
    .MemRead(cur.ctl[2]), .MemWrite(cur.ctl[1]), .Branch(cur.ctl[0]),
    .ALUOp(cur.aluop), .rt(cur.rt), .rd(cur.rd), .funct(cur.funct), .nextPc(cur.npc),
    .hit_OUT(hit_OUT), .readData1_OUT(readData1_OUT), .readData2_OUT(readData2_OUT),
    .signExImmediate_OUT(signExImmediate_OUT),
    .RegDst_OUT(RegDst_OUT), .ALUSrc_OUT(ALUSrc_OUT), .MemtoReg_OUT(MemtoReg_OUT),
    .RegWrite_OUT(RegWrite_OUT), .MemRead_OUT(MemRead_OUT), .MemWrite_OUT(MemWrite_OUT),
    .Branch_OUT(Branch_OUT), .ALUOp_OUT(ALUOp_OUT), .rt_OUT(rt_OUT), .rd_OUT(rd_OUT),
    .funct_OUT(funct_OUT), .nextPc_OUT(nextPc_OUT)
  );

  assign got = {hit_OUT, readData1_OUT, readData2_OUT, signExImmediate_OUT,
                RegDst_OUT, ALUSrc_OUT, MemtoReg_OUT, RegWrite_OUT,
                MemRead_OUT, MemWrite_OUT, Branch_OUT,
                ALUOp_OUT, rt_OUT, rd_OUT, funct_OUT, nextPc_OUT};

  // 20 ns period: rising edges at 10, 30, 50 ... leave room for a 10 ns reset pulse between edges.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    v.hit   = 1'($urandom);
    v.rd1   = $urandom;
    v.rd2   = $urandom;
    v.imm   = $urandom;
    v.ctl   = 7'($urandom);
    v.aluop = 3'($urandom);
    v.rt    = 5'($urandom);
    v.rd    = 5'($urandom);
    v.funct = 6'($urandom);
    v.npc   = $urandom;
    return v;
  endfunction

  // Wait one rising edge, predict the register contents, then compare just after the edge.
  task automatic edge_check(input string tag);
    @(posedge clk);
    exp_v = rst ? vec_t'('0) : cur;
    #1;
    check(tag, got, exp_v);
  endtask

  initial begin
    vec_t v;
    vec_t prev;
    logic [DATA_W-1:0] track [3];
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    cur    = rand_vec();
    cur.rd1 = cur.rd1 | 32'h1;

    // Async reset with non-zero inputs, asserted between edges.
    @(negedge clk);
    rst = 1'b1;
    #1 check("rst_async", got, '0);
    edge_check("rst_hold_edge1");
    edge_check("rst_hold_edge2");

    // Release with all-zero inputs; first capture is the next edge.
    @(negedge clk);
    rst = 1'b0;
    cur = '0;
    edge_check("zero_load");

    // Basic load: new inputs must not appear until the next edge.
    @(negedge clk);
    cur.hit = 1'b1; cur.rd1 = 32'd1; cur.rd2 = 32'd2; cur.imm = 32'd3;
    cur.ctl = 7'h7f; cur.aluop = 3'b100; cur.rt = 5'd5; cur.rd = 5'd6;
    cur.funct = 6'd7; cur.npc = 32'd8;
    #1 check("basic_pre_edge", got, '0);
    edge_check("basic_load");

    // Hold for 3 cycles, checking both just after and just before each edge.
    for (int i = 0; i < 3; i++) begin
      edge_check("hold_post");
      @(negedge clk);
      #8 check("hold_pre", got, exp_v);
    end

    // Per-cycle tracking of readData1.
    track[0] = 32'hFFFF_FFFF;
    track[1] = 32'hA5A5_A5A5;
    track[2] = 32'h0000_0000;
    prev = cur;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cur.rd1 = track[i];
      #1 check("track_pre_edge", readData1_OUT, prev.rd1);
      @(posedge clk);
      #1 check("track_rd1", readData1_OUT, track[i]);
      check("track_all", got, cur);
      prev = cur;
    end

    // Walk a single 1 through every control, ALUOp, rt, rd and funct bit.
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      v = '0;
      if (i < 7)       v.ctl   = 7'(1 << i);
      else if (i < 10) v.aluop = 3'(1 << (i - 7));
      else if (i < 15) v.rt    = 5'(1 << (i - 10));
      else if (i < 20) v.rd    = 5'(1 << (i - 15));
      else             v.funct = 6'(1 << (i - 20));
      cur = v;
      edge_check("walk_one");
    end

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cur = rand_vec();
      edge_check("random");
    end

    // Mid-run reset pulse of 10 ns between edges, then reload.
    @(negedge clk);
    cur = rand_vec();
    cur.npc = cur.npc | 32'h4;
    edge_check("pre_pulse_load");
    #2 rst = 1'b1;
    #1 check("pulse_clear", got, '0);
    cur = rand_vec();
    #10 rst = 1'b0;
    #1 check("pulse_after_release", got, '0);
    edge_check("pulse_reload");

    // Input change with no clock edge has no effect.
    @(negedge clk);
    prev = got;
    cur = ~cur;
    #3 check("no_edge_no_change", got, prev);
    edge_check("final_load");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
